// File: rtl/demux1_4_stream_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer: select encoding,
// per-slot FSM states and the select-to-channel decoder.
package demux_pkg;

   // Select values, the exact inverse of the 4-to-1 output mux.
   localparam logic [1:0] SEL_CH3 = 2'b00;
   localparam logic [1:0] SEL_CH2 = 2'b01;
   localparam logic [1:0] SEL_CH1 = 2'b10;
   localparam logic [1:0] SEL_CH0 = 2'b11;

   // One-entry slot occupancy.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   // Returns a one-hot vector where bit k selects channel k.
   function automatic logic [3:0] decode_sel(input logic [1:0] s);
      logic [3:0] oh;
      oh = 4'b0000;
      case (s)
         SEL_CH0: oh = 4'b0001;
         SEL_CH1: oh = 4'b0010;
         SEL_CH2: oh = 4'b0100;
         SEL_CH3: oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/demux1_4_stream_if.sv
// Bus bundle for demux1_4_stream: one tagged input stream, four output
// channels and their debug beat counters.
//
// Handshake: a transfer happens on a rising edge when valid and ready are both
// high in the cycle before it. The source holds valid and its payload stable
// until the transfer; ready may change freely and may depend on valid/sel.
interface demux1_4_stream_if #(
   parameter int DW = 2,
   parameter int CW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [1:0]    sel;
   logic [3:0]    out_valid;
   logic [3:0]    out_ready;
   logic [DW-1:0] d0, d1, d2, d3;
   logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;

   // Producer and consumers side.
   modport master (
      output in_valid, in_data, sel, out_ready,
      input  in_ready, out_valid, d0, d1, d2, d3, cnt0, cnt1, cnt2, cnt3
   );

   // Demultiplexer side.
   modport slave (
      input  in_valid, in_data, sel, out_ready,
      output in_ready, out_valid, d0, d1, d2, d3, cnt0, cnt1, cnt2, cnt3
   );
endinterface

// File: rtl/demux1_4_stream_slot.sv
// One output channel: a single-entry register with valid flag, a two-state
// occupancy FSM and a wrapping count of completed consumer handshakes.
module demux_slot
   import demux_pkg::*;
#(
   parameter int DW = 2,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   output logic          valid,
   input  logic          ready,
   output logic [DW-1:0] data,
   output logic [CW-1:0] cnt,
   output logic          can_accept
);

   slot_state_t   state_q, state_d;
   logic [DW-1:0] data_q;
   logic [CW-1:0] cnt_q;
   logic          hs;

   assign valid      = (state_q == SLOT_FULL);
   assign hs         = valid & ready;
   // Empty, or draining this cycle: a new beat can land without a bubble.
   assign can_accept = !valid | ready;
   assign data       = data_q;
   assign cnt        = cnt_q;

   // Occupancy transitions: fill on write, empty on handshake without refill.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SLOT_EMPTY: if (wr_en)        state_d = SLOT_FULL;
         SLOT_FULL:  if (hs && !wr_en) state_d = SLOT_EMPTY;
         default:                      state_d = SLOT_EMPTY;
      endcase
   end

   // State, payload and counter registers; wr_en is only raised when
   // can_accept is high, so a stalled beat is never overwritten.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (wr_en) data_q <= wr_data;
         if (hs)    cnt_q  <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/demux1_4_stream.sv
// Registered 1-to-4 stream demultiplexer. Decodes sel to a target channel,
// grants in_ready from that channel alone and fans the accept out to it.
module demux1_4_stream
   import demux_pkg::*;
#(
   parameter int DW = 2,
   parameter int CW = 8
) (
   input  logic                clk,
   input  logic                rst,
   demux1_4_stream_if.slave    bus
);

   logic [3:0]    tgt;
   logic [3:0]    can_acc;
   logic [3:0]    wr_en;
   logic [3:0]    valid_v;
   logic          accept;
   logic [DW-1:0] data_a [4];
   logic [CW-1:0] cnt_a  [4];

   assign tgt          = decode_sel(bus.sel);
   // Only the addressed channel gates the input, so one stalled consumer
   // never blocks beats headed elsewhere.
   assign bus.in_ready = |(tgt & can_acc);
   assign accept       = bus.in_valid & bus.in_ready;
   assign wr_en        = tgt & {4{accept}};

   for (genvar k = 0; k < 4; k++) begin : g_slot
      demux_slot #(.DW(DW), .CW(CW)) u_slot (
         .clk        (clk),
         .rst        (rst),
         .wr_en      (wr_en[k]),
         .wr_data    (bus.in_data),
         .valid      (valid_v[k]),
         .ready      (bus.out_ready[k]),
         .data       (data_a[k]),
         .cnt        (cnt_a[k]),
         .can_accept (can_acc[k])
      );
   end

   assign bus.out_valid = valid_v;
   assign bus.d0        = data_a[0];
   assign bus.d1        = data_a[1];
   assign bus.d2        = data_a[2];
   assign bus.d3        = data_a[3];
   assign bus.cnt0      = cnt_a[0];
   assign bus.cnt1      = cnt_a[1];
   assign bus.cnt2      = cnt_a[2];
   assign bus.cnt3      = cnt_a[3];

endmodule

// File: tb/tb_demux1_4_stream.sv
// Scoreboard bench for demux1_4_stream: per-channel expected queues filled on
// modelled accepts, drained and compared whenever a consumer handshake occurs.
module tb_demux1_4_stream;

   localparam int DW = 2;
   localparam int CW = 8;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   demux1_4_stream_if #(.DW(DW), .CW(CW)) bus ();

   demux1_4_stream #(.DW(DW), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] d_a   [4];
   logic [CW-1:0] cnt_a [4];
   assign d_a[0] = bus.d0;   assign d_a[1] = bus.d1;
   assign d_a[2] = bus.d2;   assign d_a[3] = bus.d3;
   assign cnt_a[0] = bus.cnt0; assign cnt_a[1] = bus.cnt1;
   assign cnt_a[2] = bus.cnt2; assign cnt_a[3] = bus.cnt3;

   // ---------------- reference model state ----------------
   // Channel for a select value: sel 0..3 maps to channel 3..0.
   logic [DW-1:0] exp_q [4][$];
   logic [CW-1:0] exp_cnt [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Accept side of the model: a beat lands if its channel is empty once the
   // consumer handshake of this cycle (already popped) is accounted for.
   always @(posedge clk) begin
      int t;
      t = 3 - int'(bus.sel);
      if (!rst && bus.in_valid && exp_q[t].size() == 0)
         exp_q[t].push_back(bus.in_data);
   end

   // Monitor: compares flags, counters and delivered data mid-cycle.
   always @(negedge clk) begin
      int  t;
      logic exp_rdy;
      t = 3 - int'(bus.sel);
      exp_rdy = (exp_q[t].size() == 0) || bus.out_ready[t];
      check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      for (int k = 0; k < 4; k++) begin
         check($sformatf("out_valid[%0d]", k), 32'(bus.out_valid[k]), 32'(exp_q[k].size() != 0));
         check($sformatf("cnt%0d", k), 32'(cnt_a[k]), 32'(exp_cnt[k]));
         if (!rst && exp_q[k].size() != 0 && bus.out_ready[k]) begin
            check($sformatf("d%0d", k), 32'(d_a[k]), 32'(exp_q[k][0]));
            void'(exp_q[k].pop_front());
            exp_cnt[k] = exp_cnt[k] + 1'b1;
         end
      end
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            exp_cnt[k] = '0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input logic v, input logic [1:0] s, input logic [DW-1:0] dat,
                       input logic [3:0] ordy);
      bus.in_valid  = v;
      bus.sel       = s;
      bus.in_data   = dat;
      bus.out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic [3:0] ordy);
      for (int i = 0; i < n; i++) step(1'b0, 2'(i), 2'(i), ordy);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int k = 0; k < 4; k++) exp_cnt[k] = '0;

      // Reset with a beat offered: nothing may be captured.
      rst = 1'b1;
      step(1'b1, 2'b00, 2'b11, 4'b0000);
      step(1'b1, 2'b01, 2'b10, 4'b0000);
      rst = 1'b0;
      check("reset_d0", 32'(bus.d0), 0);
      check("reset_d1", 32'(bus.d1), 0);
      check("reset_d2", 32'(bus.d2), 0);
      check("reset_d3", 32'(bus.d3), 0);
      idle(1, 4'b0000);

      // Mapping of every select value.
      step(1'b1, 2'b00, 2'b01, 4'b0000);
      step(1'b1, 2'b01, 2'b10, 4'b0000);
      step(1'b1, 2'b10, 2'b11, 4'b0000);
      step(1'b1, 2'b11, 2'b00, 4'b0000);
      bus.in_valid = 1'b0;
      check("map_d3", 32'(bus.d3), 32'h1);
      check("map_d2", 32'(bus.d2), 32'h2);
      check("map_d1", 32'(bus.d1), 32'h3);
      check("map_d0", 32'(bus.d0), 32'h0);
      check("map_out_valid", 32'(bus.out_valid), 32'hf);

      // Backpressure isolation: ch3 stalled, ch0 drained then refilled.
      step(1'b1, 2'b00, 2'b10, 4'b0000);
      idle(1, 4'b0001);
      step(1'b1, 2'b11, 2'b11, 4'b0000);
      check("bp_d3_held", 32'(bus.d3), 32'h1);
      check("bp_d0_new", 32'(bus.d0), 32'h3);
      idle(2, 4'b1111);

      // Streaming into channel 2 at full rate.
      for (int i = 0; i < 10; i++) step(1'b1, 2'b01, 2'(i), 4'b0100);
      idle(1, 4'b0100);
      check("stream_cnt2", 32'(bus.cnt2), 32'd11);

      // 256 handshakes on channel 1 wrap its counter back to where it was.
      for (int i = 0; i < 256; i++) step(1'b1, 2'b10, 2'($urandom_range(0, 3)), 4'b0010);
      idle(1, 4'b0010);
      check("wrap_cnt1", 32'(bus.cnt1), 32'd1);
      check("wrap_cnt0", 32'(bus.cnt0), 32'd2);
      check("wrap_cnt2", 32'(bus.cnt2), 32'd11);
      check("wrap_cnt3", 32'(bus.cnt3), 32'd1);

      // Random traffic with random consumer readiness.
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));

      // Reset mid-stream with channels 1 and 2 holding beats.
      idle(2, 4'b1111);
      step(1'b1, 2'b10, 2'b01, 4'b0000);
      step(1'b1, 2'b01, 2'b10, 4'b0000);
      bus.in_valid = 1'b0;
      check("pre_rst_out_valid", 32'(bus.out_valid), 32'h6);
      rst = 1'b1;
      step(1'b1, 2'b00, 2'b11, 4'b0000);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
      check("rst_cnt0", 32'(bus.cnt0), 0);
      check("rst_cnt1", 32'(bus.cnt1), 0);
      check("rst_cnt2", 32'(bus.cnt2), 0);
      check("rst_cnt3", 32'(bus.cnt3), 0);

      // Tail of random traffic after the reset, then drain.
      for (int i = 0; i < 100; i++)
         step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      idle(3, 4'b1111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/demux1_4_stream.md
# demux1_4_stream

Registered 1-to-4 stream demultiplexer, the inverse of the team's 4-to-1 output mux. Takes one 2-bit data stream plus a 2-bit select, and delivers each beat into one of four output channels, each holding its beat in a one-entry register with valid/ready handshake. Keeps a per-channel delivered-beat counter for debug. Sits between a producer that tags beats with a destination select and four independent consumers.

## Interface
Parameters:
- `DW`, 2, data width of every channel.
- `CW`, 8, width of each per-channel beat counter.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input beat present.
- `in_ready` out 1: beat accepted this cycle when `in_valid & in_ready`.
- `in_data` in DW: input beat.
- `sel` in 2: destination select, sampled with the beat.
- `out_valid` out 4: bit k means channel k holds a beat.
- `out_ready` in 4: bit k means consumer k takes channel k's beat this cycle.
- `d0`, `d1`, `d2`, `d3` out DW: channel data registers.
- `cnt0`..`cnt3` out CW: beats delivered on each channel (consumer handshakes completed).

## Operation
- Select encoding is the exact inverse of the 4-to-1 mux:
  - `sel=00` goes to channel 3 (`d3`).
  - `sel=01` goes to channel 2 (`d2`).
  - `sel=10` goes to channel 1 (`d1`).
  - `sel=11` goes to channel 0 (`d0`).
- Target channel t = decode(`sel`).
- `in_ready` is combinational: `!out_valid[t] | out_ready[t]`. It depends only on the addressed channel, so a stalled channel never blocks traffic to other channels. There is no head-of-line blocking beyond the current beat.
- On accept:
  - `d[t] <= in_data`.
  - `out_valid[t] <= 1`.
- Per channel k, each cycle:
  - Consumer handshake (`out_valid[k] & out_ready[k]`) with no new accept to k: `out_valid[k] <= 0`, and `cnt_k` increments.
  - Handshake and accept to k in the same cycle: `out_valid[k]` stays 1, `d[k]` takes the new beat, `cnt_k` increments. Full throughput, no bubble.
  - Accept with no handshake (channel was empty): `out_valid[k] <= 1`.
- Data stability: `d[k]` is not modified while `out_valid[k]=1 & !out_ready[k]`.
- Counters wrap modulo 2^CW. No saturation.
- `in_data` and `sel` are don't-care when `in_valid=0`.
- Each channel has a two-state FSM:
  - EMPTY to FULL on accept.
  - FULL to EMPTY on handshake without accept.
  - FULL to FULL on handshake with accept, or on stall.

## Timing
- Latency: a beat accepted at edge n shows on `d[t]`/`out_valid[t]` after edge n, so the consumer can take it in cycle n+1.
- Throughput: one beat per cycle in aggregate, including back-to-back beats to the same channel while its consumer holds `out_ready=1`.
- Reset values, applied at the first edge with `rst=1`:
  - `out_valid=4'b0000`.
  - `d0..d3=0`.
  - `cnt0..cnt3=0`.
  - `in_ready=1`, since all channels are empty.
- Reset mid-operation: buffered beats are discarded and counters cleared; an input handshake in the same cycle as `rst=1` is ignored.
- `out_ready` asserted on an empty channel has no effect and does not count.

## Structure
- Shared package `demux_pkg` holds:
  - select-to-channel constants (`SEL_CH3=2'b00`, `SEL_CH2=2'b01`, `SEL_CH1=2'b10`, `SEL_CH0=2'b11`);
  - the `decode_sel` function returning a one-hot 4-bit vector.
- Sub-module `demux_slot`: one instance per channel (4 total). It contains:
  - the one-entry register, valid flag and counter;
  - ports `clk`, `rst`, `wr_en`, `wr_data`, `valid`, `ready`, `data`, `cnt`, `can_accept`.
- The top level holds only the decode, the `in_ready` mux and the accept fan-out.

## Test plan
- Reset: hold `rst=1` for 2 cycles with `in_valid=1` → `out_valid=0000`, all `d*=0`, all `cnt*=0`, `in_ready=1`; no beat captured.
- Mapping: with all `out_ready=0`, send `sel=00,data=01`; `sel=01,data=10`; `sel=10,data=11`; `sel=11,data=00` → `d3=01`, `d2=10`, `d1=11`, `d0=00`, `out_valid=1111`.
- Backpressure isolation: channel 3 full with `out_ready[3]=0`.
  - Beat with `sel=00` → `in_ready=0`, `d3` unchanged.
  - Beat with `sel=11` → accepted into `d0` the same cycle.
- Streaming: `out_ready[2]=1`, 10 consecutive beats with `sel=01` and data 0,1,2,3,… → `in_ready=1` throughout, consumer sees each value one cycle after its accept, `cnt2=10`.
- Counter wrap: 256 handshakes on channel 1 with `CW=8` → `cnt1=0`, other counters unchanged.
- Reset mid-stream: `rst=1` for one cycle while `out_valid=0110` and a beat is offered → next cycle `out_valid=0000`, counters 0, offered beat lost.
